seven_seg_scan_ctrl: RTL

Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one BCD-to-seven-segment decoder. It latches a packed BCD value and steps through the digits one at a time. For each digit it drives that digit's BCD to the shared decoder, registers the decoded segments and enables that digit's anode. A blanking gap between digits prevents ghosting, and display updates are frame-synchronous so no frame shows a mix of old and new digits.

---
 rtl/seven_seg_scan_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits sharing one BCD decoder.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              dec_bcd,
    input  logic [6:0]              dec_seg,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done,
    output logic                    bcd_err
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [6:0]            SEG_OFF = 7'b1111111;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = '1;

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] display_q, display_d;
    logic [6:0]              seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic                    frame_done_q, frame_done_d;
    logic                    bcd_err_q, bcd_err_d;

    logic [3:0] cur_bcd;
    logic [6:0] show_seg;
    logic       bcd_invalid;
    logic       lz_blank;
    logic       last_digit;
    logic       blank_end;
    logic       slot_end;

    always_comb begin
        cur_bcd = 4'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_bcd = display_q[4*k +: 4];
            end
        end
    end

    assign dec_bcd = cur_bcd;

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a digit is blank while everything above and including it is zero.
    always_comb begin : lz_scan
        logic upper_zero;
        upper_zero = 1'b1;
        lz_blank   = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (display_q[4*k +: 4] == 4'd0);
            if (idx_q == IDX_W'(k)) begin
                lz_blank = upper_zero;
            end
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    assign bcd_invalid = (cur_bcd > 4'd9);
    assign show_seg    = (bcd_invalid || lz_blank) ? SEG_OFF : dec_seg;
    assign last_digit  = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign blank_end   = (state_q == BLANK) && (cnt_q == CNT_W'(BLANK_CYCLES - 1));
    assign slot_end    = (state_q == SHOW) && (cnt_q == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = BLANK;
        end else begin
            case (state_q)
                BLANK:   if (blank_end) state_d = SHOW;
                SHOW:    if (slot_end)  state_d = BLANK;
                default: state_d = BLANK;
            endcase
        end
    end

    // Anodes and segments only ever change together, on slot-phase edges.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        display_d    = display_q;
        seg_n_d      = seg_n_q;
        an_n_d       = an_n_q;
        frame_done_d = 1'b0;
        bcd_err_d    = bcd_err_q;

        if (load) begin
            shadow_d  = digits_in;
            bcd_err_d = 1'b0;
        end

        if (!en) begin
            cnt_d     = '0;
            idx_d     = '0;
            seg_n_d   = SEG_OFF;
            an_n_d    = AN_OFF;
            display_d = load ? digits_in : shadow_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (blank_end) begin
                seg_n_d = show_seg;
                an_n_d  = ~(NUM_DIGITS'(1) << idx_q);
                if (bcd_invalid) begin
                    bcd_err_d = 1'b1;
                end
            end
            if (slot_end) begin
                cnt_d   = '0;
                seg_n_d = SEG_OFF;
                an_n_d  = AN_OFF;
                idx_d   = last_digit ? '0 : idx_q + IDX_W'(1);
                if (last_digit) begin
                    frame_done_d = 1'b1;
                    display_d    = load ? digits_in : shadow_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            display_q    <= '0;
            seg_n_q      <= SEG_OFF;
            an_n_q       <= AN_OFF;
            frame_done_q <= 1'b0;
            bcd_err_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            display_q    <= display_d;
            seg_n_q      <= seg_n_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;
            bcd_err_q    <= bcd_err_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;
    assign bcd_err    = bcd_err_q;

endmodule
